// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the 7-segment display block.
//   - state_t        : conversion FSM states (IDLE / CONVERT / LOAD)
//   - DIGITS, NUM_W  : default digit count and input width
//   - SEG_0..SEG_9   : active-low segment patterns, bit0=a .. bit6=g
//   - SEG_OFF        : all segments off
//   - bcd_to_seg()   : nibble -> pattern lookup; non-decimal nibbles show off
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        LOAD    = 2'd2
    } state_t;

    localparam int DIGITS = 5;
    localparam int NUM_W  = 14;

    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_encode.sv
// seg_encode: combinational BCD nibble to 7-segment decoder.
//   bcd   : BCD digit 0..9
//   blank : force all segments off (leading-zero suppression)
//   seg   : active-low segments, bit0=a .. bit6=g
module seg_encode (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);
    import seg_pkg::*;

    always_comb begin
        seg = blank ? SEG_OFF : bcd_to_seg(bcd);
    end

endmodule

// File: rtl/seg_display.sv
// seg_display: binary to 5-digit 7-segment display via serial double-dabble.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   num       : unsigned value to show
//   num_valid : one-cycle conversion request
//   busy      : conversion in progress (CONVERT or LOAD)
//   done      : one-cycle pulse after HEX0..HEX4 update
//   HEX0..4   : active-low segments, HEX0 least significant
// Optional feature: define SEG_BLANK_EN to blank leading zeros (HEX0 always
// shows a digit). Latency is the same either way.
module seg_display #(
    parameter int DIGITS = seg_pkg::DIGITS,
    parameter int NUM_W  = seg_pkg::NUM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NUM_W-1:0] num,
    input  logic             num_valid,
    output logic             busy,
    output logic             done,
    output logic [6:0]       HEX0,
    output logic [6:0]       HEX1,
    output logic [6:0]       HEX2,
    output logic [6:0]       HEX3,
    output logic [6:0]       HEX4
);
    import seg_pkg::*;

    state_t                  state, state_nxt;
    logic [NUM_W-1:0]        shift_q;
    logic [NUM_W-1:0]        pend_val;
    logic                    pend;
    logic [4*DIGITS-1:0]     bcd_q;
    logic [4*DIGITS-1:0]     bcd_adj;
    logic [3:0]              cnt;
    logic                    done_q;
    logic                    start;
    logic [NUM_W-1:0]        start_val;
    logic [DIGITS-1:0]       blank;
    logic [DIGITS-1:0][6:0]  seg;
    logic [DIGITS-1:0][6:0]  hex_q;

    // A fresh strobe in IDLE beats a stale pending value (last write wins).
    assign start     = (state == IDLE) && (num_valid || pend);
    assign start_val = num_valid ? num : pend_val;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (num_valid || pend) state_nxt = CONVERT;
            CONVERT: if (cnt == 4'(NUM_W-1)) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state != IDLE);
    end

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt      <= '0;
            pend     <= 1'b0;
            pend_val <= '0;
            done_q   <= 1'b0;
            hex_q    <= {DIGITS{SEG_OFF}};
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    shift_q <= start_val;
                    bcd_q   <= '0;
                    cnt     <= '0;
                    pend    <= 1'b0;
                end
                CONVERT: begin
                    bcd_q   <= {bcd_adj[4*DIGITS-2:0], shift_q[NUM_W-1]};
                    shift_q <= shift_q << 1;
                    cnt     <= cnt + 4'd1;
                end
                LOAD: begin
                    // bcd_q is final here, so the display never sees a partial value.
                    hex_q  <= seg;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
            // Requests during CONVERT/LOAD park in a one-deep slot.
            if (busy && num_valid) begin
                pend     <= 1'b1;
                pend_val <= num;
            end
        end
    end

    // Leading-zero blanking: a digit blanks only if it and every digit above
    // it are zero. HEX0 is never blanked.
    always_comb begin
        blank = '0;
`ifdef SEG_BLANK_EN
        begin
            logic lead;
            lead = 1'b1;
            for (int i = DIGITS-1; i > 0; i--) begin
                lead     = lead && (bcd_q[4*i +: 4] == 4'd0);
                blank[i] = lead;
            end
        end
`endif
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_enc
        seg_encode u_enc (
            .bcd   (bcd_q[4*g +: 4]),
            .blank (blank[g]),
            .seg   (seg[g])
        );
    end

    assign done = done_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];

endmodule

// File: tb/tb_seg_display.sv
// tb_seg_display: scoreboard bench for seg_display. Expected displays and
// done cycles are queued when stimulus is driven and compared on done.
// Honors SEG_BLANK_EN for the expected digit model.
module tb_seg_display;

    typedef struct {
        logic [34:0] hex;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [13:0] num = '0;
    logic        num_valid = 1'b0;
    logic        busy, done;
    logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   dones = 0;
    exp_t q[$];

    localparam logic [34:0] ALL_OFF = {5{7'h7F}};

    seg_display dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .num       (num),
        .num_valid (num_valid),
        .busy      (busy),
        .done      (done),
        .HEX0      (HEX0),
        .HEX1      (HEX1),
        .HEX2      (HEX2),
        .HEX3      (HEX3),
        .HEX4      (HEX4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] model(input int n);
        logic [6:0]  pat [10];
        logic [34:0] r;
        int          div, d;
        bit          lead;
        pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        r = '0;
        lead = 1'b1;
        div = 10000;
        for (int i = 4; i >= 0; i--) begin
            d = (n / div) % 10;
            div = div / 10;
`ifdef SEG_BLANK_EN
            if (lead && d == 0 && i > 0) r[7*i +: 7] = 7'h7F;
            else begin
                lead = 1'b0;
                r[7*i +: 7] = pat[d];
            end
`else
            r[7*i +: 7] = pat[d];
`endif
        end
        return r;
    endfunction

    // Monitor: compare on done, check done width and that HEX never
    // changes outside a done update.
    logic [34:0] shown = ALL_OFF;
    bit          prev_done = 1'b0;
    always @(negedge clk) begin
        logic [34:0] hv;
        exp_t e;
        hv = {HEX4, HEX3, HEX2, HEX1, HEX0};
        if (!rst_n) begin
            shown = ALL_OFF;
            prev_done = 1'b0;
        end else begin
            if (prev_done) chk("done_len", done, 1'b0);
            if (done) begin
                dones++;
                if (q.size() == 0) chk("unexpected_done", 1'b1, 1'b0);
                else begin
                    e = q.pop_front();
                    chk("hex", hv, e.hex);
                    chk("done_cyc", cyc, e.cyc);
                end
                shown = hv;
            end else if (hv !== shown) begin
                chk("hex_hold", hv, shown);
                shown = hv;
            end
            prev_done = done;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Strobe n for one cycle; accept edge is the next posedge.
    task automatic send(input int n, input bit push);
        exp_t e;
        num = 14'(n);
        num_valid = 1'b1;
        if (push) begin
            e.hex = model(n);
            e.cyc = cyc + 1 + 15;
            q.push_back(e);
        end
        tick(1);
        num_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (q.size() == 0 && !busy) begin ok = 1'b1; break; end
            tick(1);
        end
        if (!ok) chk("timeout", 1'b0, 1'b1);
        tick(2);
    endtask

    initial begin
        exp_t e;
        int   a, d0;

        tick(3);
        chk("rst_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, ALL_OFF);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // num = 6
        send(6, 1'b1);
        chk("busy_conv", busy, 1'b1);
        wait_idle();
        chk("n6_hex0", HEX0, 7'h02);
`ifdef SEG_BLANK_EN
        chk("n6_hex4_1", {HEX4, HEX3, HEX2, HEX1}, {4{7'h7F}});
`else
        chk("n6_hex4_1", {HEX4, HEX3, HEX2, HEX1}, {4{7'h40}});
`endif

        // maximum value
        send(16383, 1'b1);
        wait_idle();
        chk("max_hex", {HEX4, HEX3, HEX2, HEX1, HEX0},
            {7'h79, 7'h02, 7'h30, 7'h00, 7'h30});

        // zero
        send(0, 1'b1);
        wait_idle();
`ifdef SEG_BLANK_EN
        chk("zero_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, {{4{7'h7F}}, 7'h40});
`else
        chk("zero_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, {5{7'h40}});
`endif

        // pending: 1234 then 42, 77 during busy; 77 wins
        a = cyc + 1;
        send(1234, 1'b1);
        tick(3);
        send(42, 1'b0);
        tick(2);
        e.hex = model(77);
        e.cyc = a + 31;
        q.push_back(e);
        send(77, 1'b0);
        wait_idle();
        chk("pend_final", {HEX4, HEX3, HEX2, HEX1, HEX0}, model(77));

        // a couple of mid-range values
        send(9050, 1'b1);
        wait_idle();
        send(307, 1'b1);
        wait_idle();

        // reset at cycle 7 of a 9999 conversion
        d0 = dones;
        send(9999, 1'b0);
        tick(6);
        rst_n = 1'b0;
        tick(1);
        @(negedge clk);
        chk("midrst_hex", {HEX4, HEX3, HEX2, HEX1, HEX0}, ALL_OFF);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        tick(1);
        rst_n = 1'b1;
        tick(25);
        chk("midrst_no_done", dones - d0, 0);
        chk("midrst_hold", {HEX4, HEX3, HEX2, HEX1, HEX0}, ALL_OFF);

        send(5, 1'b1);
        wait_idle();
        chk("after_rst_hex0", HEX0, 7'h12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
